// File: rtl/rf_write_arbiter_pkg.sv
// rf_write_arbiter_pkg
//   Shared definitions for the register-file write arbiter slice.
//   - Unified RF address space geometry: 6-bit addresses. GPRs sit at 0x00..0x1F,
//     HI/LO sit above them, and CP0 slots follow.
//   - Data bus width (DATA_BUS).
//   - Helper that recognises the hard-wired $zero slot.
package rf_write_arbiter_pkg;

  localparam int DATA_BUS      = 32;
  localparam int RF_ADDR_WIDTH = 6;

  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
  typedef logic [DATA_BUS-1:0]      rf_data_t;

  localparam rf_addr_t RF_REG_ZERO = 6'h00;
  localparam rf_addr_t RF_REG_HI   = 6'h21;
  localparam rf_addr_t RF_REG_LO   = 6'h22;

  // Writes to $zero are architecturally discarded.
  function automatic logic is_zero_slot(input rf_addr_t addr);
    return addr == RF_REG_ZERO;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_picker.sv
// rf_write_arbiter_picker
//   Combinational round-robin picker. It selects the first valid requester,
//   scanning upward from prio_ptr and wrapping modulo NUM_REQ.
//   Ports:
//     req_valid   in  [NUM_REQ-1:0]  per-requester request
//     prio_ptr    in  [PTR_W-1:0]    index holding highest priority this cycle
//     grant       out [NUM_REQ-1:0]  one-hot winner, zero when nothing is valid
//     grant_idx   out [PTR_W-1:0]    binary index of the winner
//     grant_any   out                at least one requester is valid
module rf_write_arbiter_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   prio_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_any
);

  // Distance of idx from base, walking upward around the ring.
  function automatic int ring_dist(input int idx, input int base);
    return (idx - base + NUM_REQ) % NUM_REQ;
  endfunction

  int best_dist;

  // The valid requester closest to prio_ptr (ring distance) wins.
  always_comb begin
    best_dist = NUM_REQ;
    grant_idx = '0;
    grant_any = 1'b0;
    grant     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (ring_dist(i, int'(prio_ptr)) < best_dist)) begin
        best_dist = ring_dist(i, int'(prio_ptr));
        grant_idx = PTR_W'(i);
        grant_any = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = grant_any && (grant_idx == PTR_W'(i));
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single unified register-file write port among NUM_REQ requesters
//   (ROB commit ports, the CP0 Count/Compare updater and the exception unit).
//   It grants one write per cycle with a zero-latency ready and drives a
//   registered write port.
//   Configuration macro:
//     RF_ARB_FIXED_PRIO_EN  when defined, the lowest index always wins and
//                           prio_ptr does not exist. The default is round-robin.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     stall           RF cannot take a write; blocks granting this cycle
//     req_valid       [NUM_REQ]               per-requester write request
//     req_addr        [NUM_REQ*RF_ADDR_WIDTH] flattened unified RF addresses
//     req_data        [NUM_REQ*DATA_BUS]      flattened write data
//     req_ready       [NUM_REQ]               one-hot grant or zero (combinational)
//     rf_write_en     registered write enable
//     rf_write_addr   registered write address
//     rf_write_data   registered write data
//     grant_id        index of the requester whose write is on the port
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*RF_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_BUS-1:0]      req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rf_write_en,
  output logic [RF_ADDR_WIDTH-1:0]         rf_write_addr,
  output logic [DATA_BUS-1:0]              rf_write_data,
  output logic [PTR_W-1:0]                 grant_id
);

  logic [NUM_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic               accept_p0;
  rf_addr_t           sel_addr_p0;
  rf_data_t           sel_data_p0;

  logic               wr_vld_p1;
  rf_addr_t           wr_addr_p1;
  rf_data_t           wr_data_p1;
  logic [PTR_W-1:0]   wr_id_p1;

`ifdef RF_ARB_FIXED_PRIO_EN
  // Priority encoder: the lowest index wins, so scan downward and let the
  // last hit stand.
  always_comb begin
    pick_idx    = '0;
    pick_any    = 1'b0;
    pick_onehot = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        pick_idx = PTR_W'(i);
        pick_any = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_onehot[i] = pick_any && (pick_idx == PTR_W'(i));
    end
  end
`else
  logic [PTR_W-1:0] prio_ptr;

  rf_write_arbiter_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_valid (req_valid),
    .prio_ptr  (prio_ptr),
    .grant     (pick_onehot),
    .grant_idx (pick_idx),
    .grant_any (pick_any)
  );

  // After a grant, the requester just past the winner gets the highest priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_ptr <= '0;
    end else if (accept_p0) begin
      prio_ptr <= (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end
`endif

  // ---- stage p0: grant and operand select ----
  // A grant is only offered while the RF can take it and reset is low, so
  // ready doubles as the accept strobe.
  assign accept_p0 = pick_any && !rst && !stall;
  assign req_ready = accept_p0 ? pick_onehot : '0;

  always_comb begin
    sel_addr_p0 = '0;
    sel_data_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) begin
        sel_addr_p0 = req_addr[i*RF_ADDR_WIDTH +: RF_ADDR_WIDTH];
        sel_data_p0 = req_data[i*DATA_BUS +: DATA_BUS];
      end
    end
  end

  // ---- stage p1: registered write port ----
  // A $zero write is still accepted and recorded as the last write, but it
  // never raises the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      wr_id_p1   <= '0;
    end else begin
      wr_vld_p1 <= accept_p0 && !is_zero_slot(sel_addr_p0);
      if (accept_p0) begin
        wr_addr_p1 <= sel_addr_p0;
        wr_data_p1 <= sel_data_p0;
        wr_id_p1   <= pick_idx;
      end
    end
  end

  // Reset during the write cycle drops the write. The requester has already
  // seen its accept, so the write is simply lost.
  assign rf_write_en   = wr_vld_p1 && !rst;
  assign rf_write_addr = wr_addr_p1;
  assign rf_write_data = wr_data_p1;
  assign grant_id      = wr_id_p1;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  localparam int N  = 4;
  localparam int PW = 2;
  localparam int AW = 6;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rf_write_en;
  logic [AW-1:0]   rf_write_addr;
  logic [DW-1:0]   rf_write_data;
  logic [PW-1:0]   grant_id;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.NUM_REQ(N), .PTR_W(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .grant_id      (grant_id)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Reference model: winner = first valid index scanning up from the pointer,
  // and the write appears one cycle later.
  int            m_ptr;
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [PW-1:0] m_id;
  int            win;
  logic [N-1:0]  exp_ready;

  initial begin
    m_ptr = 0; m_en = 1'b0; m_addr = '0; m_data = '0; m_id = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      win = -1;
      if (!rst && !stall) begin
        for (int k = 0; k < N; k++) begin
          if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        end
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      check("model_ready", 64'(req_ready), 64'(exp_ready));
      check("model_en", 64'(rf_write_en), 64'(m_en && !rst));
      check("model_addr", 64'(rf_write_addr), 64'(m_addr));
      check("model_data", 64'(rf_write_data), 64'(m_data));
      check("model_id", 64'(grant_id), 64'(m_id));
      if (rst) begin
        m_ptr = 0; m_en = 1'b0; m_addr = '0; m_data = '0; m_id = '0;
      end else if (win >= 0) begin
        m_addr = req_addr[win*AW +: AW];
        m_data = req_data[win*DW +: DW];
        m_en   = (m_addr != 0);
        m_id   = PW'(win);
`ifndef RF_ARB_FIXED_PRIO_EN
        m_ptr  = (win + 1) % N;
`endif
      end else begin
        m_en = 1'b0;
      end
    end
  end

  logic [N-1:0] acc;
  logic [N-1:0] exp_v;
`ifdef RF_ARB_FIXED_PRIO_EN
  localparam logic [N-1:0]  ZF_READY = 4'b0010;
  localparam logic [AW-1:0] ZF_ADDR  = 6'h09;
  localparam logic [PW-1:0] ZF_ID    = 2'd1;
`else
  localparam logic [N-1:0]  ZF_READY = 4'b0100;
  localparam logic [AW-1:0] ZF_ADDR  = 6'h0A;
  localparam logic [PW-1:0] ZF_ID    = 2'd2;
`endif

  initial begin
    rst = 1'b1; stall = 1'b0; req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_req(i, AW'(8 + i), 32'hA000_0000 + DW'(i));

    // Reset holds ready and enable low.
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_en", 64'(rf_write_en), 64'h0);
    step();
    rst = 1'b0;

`ifdef RF_ARB_FIXED_PRIO_EN
    req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("fixed_ready", 64'(req_ready), 64'h2);
      step();
    end
    req_valid = '0;
    step();
`else
    // Round-robin sweep 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_v = 4'b0001 << (k % 4);
      check("rr_ready", 64'(req_ready), 64'(exp_v));
      if (k > 0) begin
        check("rr_en", 64'(rf_write_en), 64'h1);
        check("rr_addr", 64'(rf_write_addr), 64'(8 + ((k - 1) % 4)));
        check("rr_data", 64'(rf_write_data), 64'h0A000_0000 + 64'((k - 1) % 4));
      end
      step();
    end
    req_valid = '0;
    @(negedge clk);
    check("rr_last_en", 64'(rf_write_en), 64'h1);
    check("rr_last_addr", 64'(rf_write_addr), 64'h0B);
    step();

    // Pointer wrap: grant 2 leaves pointer at 3, then 0 wins over 1.
    req_valid = 4'b0100;
    @(negedge clk);
    check("wrap_pre_ready", 64'(req_ready), 64'h4);
    step();
    req_valid = 4'b0011;
    @(negedge clk);
    check("wrap_ready", 64'(req_ready), 64'h1);
    step();
    @(negedge clk);
    check("wrap_ptr1_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    @(negedge clk);
    check("wrap_en", 64'(rf_write_en), 64'h1);
    check("wrap_addr", 64'(rf_write_addr), 64'h09);
    step();
`endif

    // Stall blocks the grant; it is granted once the stall drops.
    stall = 1'b1;
    req_valid = 4'b0100;
    set_req(2, 6'h21, 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_ready", 64'(req_ready), 64'h0);
      check("stall_en", 64'(rf_write_en), 64'h0);
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    check("unstall_ready", 64'(req_ready), 64'h4);
    step();
    req_valid = '0;
    @(negedge clk);
    check("unstall_en", 64'(rf_write_en), 64'h1);
    check("unstall_addr", 64'(rf_write_addr), 64'h21);
    check("unstall_data", 64'(rf_write_data), 64'hDEADBEEF);
    check("unstall_id", 64'(grant_id), 64'h2);
    step();

    // $zero write: accepted, the pointer advances, but no enable follows.
    set_req(1, 6'h00, 32'h0000_1234);
    req_valid = 4'b0010;
    @(negedge clk);
    check("zero_ready", 64'(req_ready), 64'h2);
    step();
    set_req(1, 6'h09, 32'hA000_0001);
    set_req(2, 6'h0A, 32'hA000_0002);
    req_valid = 4'b0110;
    @(negedge clk);
    check("zero_en", 64'(rf_write_en), 64'h0);
    check("zero_next_ready", 64'(req_ready), 64'(ZF_READY));
    step();
    req_valid = '0;
    @(negedge clk);
    check("zero_next_addr", 64'(rf_write_addr), 64'(ZF_ADDR));
    check("zero_next_id", 64'(grant_id), 64'(ZF_ID));
    step();

    // Reset in the write cycle drops the write and rewinds the pointer.
    req_valid = 4'b0001;
    @(negedge clk);
    check("midrst_grant", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_en", 64'(rf_write_en), 64'h0);
    check("midrst_ready", 64'(req_ready), 64'h0);
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    check("postrst_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    step();

    // Random traffic under the model, with stalls, resets, $zero writes and conflicts.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      rst   = ($urandom_range(0, 99) < 2);
      stall = ($urandom_range(0, 99) < 20);
      for (int i = 0; i < N; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          req_valid[i] = 1'b1;
          set_req(i, AW'($urandom_range(0, 7)), $urandom);
        end
      end
    end
    rst = 1'b0; stall = 1'b0; req_valid = '0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
